alu_op_sequencer: RTL and testbench

//  Issues decoded integer ops to the execute-stage Arithmetic_Unit and collects its results.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_decode.sv | 60 ++++++
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes, RV32I opcodes and sequencer states.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ALU_CTRL_W_DEF = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational opcode/funct3/funct7_5 -> ALU control decode.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] ctrl,
    output logic       is_branch,
    output logic       use_imm,
    output logic       illegal
);

    always_comb begin
        ctrl      = ALU_ADD;
        is_branch = 1'b0;
        use_imm   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                use_imm = (opcode == OP_I);
                case (funct3)
                    3'b000: ctrl = (funct7_5 && !use_imm) ? ALU_SUB : ALU_ADD;
                    3'b001: ctrl = ALU_SLL;
                    3'b010: ctrl = ALU_SLT;
                    3'b011: ctrl = ALU_SLTU;
                    3'b100: ctrl = ALU_XOR;
                    3'b101: ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl = ALU_OR;
                    3'b111: ctrl = ALU_AND;
                    default: ctrl = ALU_ADD;
                endcase
                // For I-type, bit 30 is immediate data except on the shift encodings
                if (use_imm)
                    illegal = (funct3 == 3'b001) && funct7_5;
                else
                    illegal = funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            OP_BR: begin
                is_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   ctrl = ALU_SUB;
                    2'b10:   ctrl = ALU_SLT;
                    2'b11:   ctrl = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues decoded ops to an external ALU, returns result/branch info.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic [XLEN-1:0]       in_rs1,
    input  logic [XLEN-1:0]       in_rs2,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_pc,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic                  out_taken,
    output logic [XLEN-1:0]       out_target,
    output logic                  out_illegal
);

    logic [3:0]      w_dec_ctrl;
    logic            w_dec_branch;
    logic            w_dec_use_imm;
    logic            w_dec_illegal;
    logic [3:0]      w_alu_ctrl;
    logic            w_taken;

    state_t          r_state;
    logic [3:0]      r_ctrl;
    logic            r_is_branch;
    logic [2:0]      r_funct3;
    logic            r_taken;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;

    alu_op_decode u_decode (
        .opcode    (in_opcode),
        .funct3    (in_funct3),
        .funct7_5  (in_funct7_5),
        .ctrl      (w_dec_ctrl),
        .is_branch (w_dec_branch),
        .use_imm   (w_dec_use_imm),
        .illegal   (w_dec_illegal)
    );

    assign in_ready = (r_state == ST_IDLE);

    // ALU sees the held op only while a pass is active; otherwise it idles at reset values
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        w_alu_ctrl = ALU_ADD;
        case (r_state)
            ST_EXEC1: begin
                alu_a      = r_a;
                alu_b      = r_b;
                w_alu_ctrl = r_ctrl;
            end
            ST_EXEC2: begin
                alu_a      = r_pc;
                alu_b      = r_imm;
                w_alu_ctrl = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(w_alu_ctrl);

    // funct3[2] picks the less-than flag over equality; funct3[0] inverts the sense
    assign w_taken = (r_funct3[2] ? alu_result[0] : alu_zero) ^ r_funct3[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= ALU_ADD;
            r_is_branch <= 1'b0;
            r_funct3    <= '0;
            r_taken     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_pc        <= '0;
            r_imm       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_taken   <= 1'b0;
            out_target  <= '0;
            out_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ctrl      <= w_dec_ctrl;
                        r_is_branch <= w_dec_branch;
                        r_funct3    <= in_funct3;
                        r_a         <= in_rs1;
                        r_b         <= w_dec_use_imm ? in_imm : in_rs2;
                        r_pc        <= in_pc;
                        r_imm       <= in_imm;
                        if (w_dec_illegal) begin
                            out_valid   <= 1'b1;
                            out_illegal <= 1'b1;
                            out_result  <= '0;
                            out_taken   <= 1'b0;
                            out_target  <= '0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_EXEC1;
                        end
                    end
                end
                ST_EXEC1: begin
                    if (r_is_branch) begin
                        r_taken <= w_taken;
                        r_state <= ST_EXEC2;
                    end else begin
                        out_valid   <= 1'b1;
                        out_result  <= alu_result;
                        out_taken   <= 1'b0;
                        out_target  <= '0;
                        out_illegal <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end
                ST_EXEC2: begin
                    out_valid   <= 1'b1;
                    out_result  <= '0;
                    out_taken   <= r_taken;
                    out_target  <= alu_result;
                    out_illegal <= 1'b0;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_result  <= '0;
                        out_taken   <= 1'b0;
                        out_target  <= '0;
                        out_illegal <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed bench for alu_op_sequencer paired with an ALU model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    localparam logic [6:0] C_OP_R  = 7'b0110011;
    localparam logic [6:0] C_OP_I  = 7'b0010011;
    localparam logic [6:0] C_OP_BR = 7'b1100011;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(.XLEN(32), .ALU_CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_taken(out_taken),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    // Arithmetic unit model
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd6: alu_result = alu_a << alu_b[4:0];
            4'd7: alu_result = alu_a >> alu_b[4:0];
            4'd8: alu_result = $signed(alu_a) >>> alu_b[4:0];
            4'd9: alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7_5 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1; first-sample ALU ports are captured
    task automatic wait_resp(output int lat, output logic [31:0] sa,
                             output logic [31:0] sb, output logic [3:0] sc);
        lat = 1;
        sa = alu_a; sb = alu_b; sc = alu_ctrl;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_taken, out_illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {out_taken, out_illegal}); end
        checks++; if ({out_result, out_target} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {out_result, out_target}); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== 68'd0) begin errors++; $display("FAIL reset_alu_ports got=%h exp=0", {alu_a, alu_b, alu_ctrl}); end
    endtask

    task automatic test_alu_ops();
        int lat; logic [31:0] sa, sb; logic [3:0] sc;
        issue(C_OP_R, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
        checks++; if ({sa, sb, sc} !== {32'd5, 32'd7, 4'd0}) begin errors++; $display("FAIL add_alu_drive got=%h %h %h exp=5 7 0", sa, sb, sc); end
        checks++; if (out_result !== 32'd12) begin errors++; $display("FAIL add_result got=%h exp=0000000c", out_result); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready_resp got=%b exp=0", in_ready); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== 68'd0) begin errors++; $display("FAIL add_alu_idle_resp got=%h exp=0", {alu_a, alu_b, alu_ctrl}); end
        ack();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL add_ack got=%b exp=01", {out_valid, in_ready}); end

        issue(C_OP_R, 3'b000, 1'b1, 32'd0, 32'd1, 32'd0, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if (sc !== 4'd1) begin errors++; $display("FAIL sub_ctrl got=%h exp=1", sc); end
        checks++; if (out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_result got=%h exp=ffffffff", out_result); end
        ack();

        // Immediate carries the SRAI encoding bit and upper junk; only [4:0] shifts
        issue(C_OP_I, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if (sc !== 4'd8) begin errors++; $display("FAIL srai_ctrl got=%h exp=8", sc); end
        checks++; if (out_result !== 32'hF800_0000) begin errors++; $display("FAIL srai_result got=%h exp=f8000000", out_result); end
        ack();

        issue(C_OP_I, 3'b010, 1'b0, 32'hFFFF_FFFD, 32'd0, 32'd2, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if (out_result !== 32'd1) begin errors++; $display("FAIL slti_result got=%h exp=1", out_result); end
        ack();

        issue(C_OP_R, 3'b100, 1'b0, 32'hF0F0_1234, 32'h0FF0_1111, 32'd0, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if (out_result !== 32'hFF00_0325) begin errors++; $display("FAIL xor_result got=%h exp=ff000325", out_result); end
        ack();

        issue(C_OP_R, 3'b011, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if ({lat, out_illegal} !== {32'd1, 1'b1}) begin errors++; $display("FAIL r_f7_illegal got lat=%0d ill=%b exp lat=1 ill=1", lat, out_illegal); end
        ack();
    endtask

    task automatic test_branch();
        int lat; logic [31:0] sa, sb; logic [3:0] sc;
        issue(C_OP_BR, 3'b110, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100);
        wait_resp(lat, sa, sb, sc);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bltu_latency got=%0d exp=3", lat); end
        checks++; if (sc !== 4'd9) begin errors++; $display("FAIL bltu_ctrl got=%h exp=9", sc); end
        checks++; if ({out_taken, out_target, out_result} !== {1'b1, 32'hF8, 32'd0}) begin errors++; $display("FAIL bltu_resp got=%b %h %h exp=1 000000f8 0", out_taken, out_target, out_result); end
        ack();

        issue(C_OP_BR, 3'b000, 1'b0, 32'd9, 32'd9, 32'h20, 32'h40);
        wait_resp(lat, sa, sb, sc);
        checks++; if ({out_taken, out_target} !== {1'b1, 32'h60}) begin errors++; $display("FAIL beq_resp got=%b %h exp=1 00000060", out_taken, out_target); end
        ack();

        issue(C_OP_BR, 3'b001, 1'b0, 32'd9, 32'd9, 32'h20, 32'h40);
        wait_resp(lat, sa, sb, sc);
        checks++; if (out_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got=%b exp=0", out_taken); end
        ack();

        issue(C_OP_BR, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0);
        wait_resp(lat, sa, sb, sc);
        checks++; if ({out_taken, out_target} !== {1'b0, 32'h10}) begin errors++; $display("FAIL bge_wrap got=%b %h exp=0 00000010", out_taken, out_target); end
        ack();

        issue(C_OP_BR, 3'b010, 1'b0, 32'd1, 32'd2, 32'd4, 32'd8);
        wait_resp(lat, sa, sb, sc);
        checks++; if ({lat, out_illegal} !== {32'd1, 1'b1}) begin errors++; $display("FAIL br_f3_illegal got lat=%0d ill=%b exp lat=1 ill=1", lat, out_illegal); end
        ack();
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] sa, sb; logic [3:0] sc;
        issue(7'h37, 3'b000, 1'b0, 32'd3, 32'd4, 32'd5, 32'd6);
        wait_resp(lat, sa, sb, sc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lui_latency got=%0d exp=1", lat); end
        checks++; if ({out_illegal, out_taken, out_result, out_target} !== {1'b1, 1'b0, 64'd0}) begin errors++; $display("FAIL lui_resp got=%b%b %h %h exp=10 0 0", out_illegal, out_taken, out_result, out_target); end
        checks++; if ({sa, sb, sc, alu_a, alu_b, alu_ctrl} !== 136'd0) begin errors++; $display("FAIL lui_alu_ports got=%h %h %h exp=0", alu_a, alu_b, alu_ctrl); end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] sa, sb; logic [3:0] sc;
        issue(C_OP_R, 3'b110, 1'b0, 32'h3, 32'h4, 32'd0, 32'd0);
        wait_resp(lat, sa, sb, sc);
        in_valid = 1'b1; in_opcode = C_OP_R; in_funct3 = 3'b111; in_rs1 = 32'hFF; in_rs2 = 32'h0F;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 32'h7}) begin errors++; $display("FAIL hold_cycle%0d got=%b%b %h exp=10 00000007", i, out_valid, in_ready, out_result); end
        end
        in_valid = 1'b0;
        ack();
        issue(C_OP_R, 3'b111, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'd0);
        wait_resp(lat, sa, sb, sc);
        checks++; if ({lat, out_result} !== {32'd2, 32'h0F}) begin errors++; $display("FAIL next_op got lat=%0d res=%h exp lat=2 res=0000000f", lat, out_result); end
        ack();
    endtask

    task automatic test_reset_mid_op();
        issue(C_OP_BR, 3'b000, 1'b0, 32'd1, 32'd1, 32'd4, 32'd8);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exec2_valid got=%b exp=0", out_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({out_valid, in_ready, out_taken, out_target} !== {3'b010, 32'd0}) begin errors++; $display("FAIL midreset got=%b%b%b %h exp=010 0", out_valid, in_ready, out_taken, out_target); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL midreset_no_resp got=%b exp=01", {out_valid, in_ready}); end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0;
        @(posedge clk); #1;
        test_reset();
        test_alu_ops();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
